alu_pipe: RTL and testbench

//  Registered, handshaked successor to the combinational 4-bit ALU and 16-bit add/sub/RED datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/sat_lane_adder.sv | 23 ++
 rtl/alu_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined ALU: opcodes, FSM states,
// byte-count and saturation-limit helpers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_PADD = 3'd2,
        OP_RED  = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RED_ACC = 1'b1
    } alu_state_e;

    function automatic int unsigned num_bytes(input int unsigned w);
        return w / 8;
    endfunction

    // Limits are returned in 64 bits; callers cast down to their own width.
    function automatic logic [63:0] sat_max(input int unsigned n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/sat_lane_adder.sv
// N-bit signed adder with carry-in; clamps to the signed range on overflow.
module sat_lane_adder
    import alu_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         ovfl
);

    localparam logic [N-1:0] MAX_V = N'(sat_max(N));
    localparam logic [N-1:0] MIN_V = N'(sat_min(N));

    logic [N-1:0] raw;

    assign raw  = a + b + {{(N-1){1'b0}}, cin};
    assign ovfl = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);
    assign sum  = ovfl ? (a[N-1] ? MIN_V : MAX_V) : raw;

endmodule

// File: rtl/alu_pipe.sv
// Registered, handshaked ALU: single-cycle ADD/SUB/PADD/XOR/NAND and an
// iterative signed byte reduction (RED), one operation in flight.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned LANE_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovfl,
    output logic         zero,
    output logic         neg,
    output logic         illegal
);

    localparam int unsigned NB = num_bytes(W);
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned NL = W / LANE_W;

    alu_state_e    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          accept;

    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ADD/SUB share one full-width saturating adder; SUB feeds ~b with cin=1.
    logic         is_sub;
    logic [W-1:0] add_sum;
    logic         add_ovfl;

    assign is_sub = (op == OP_SUB);

    sat_lane_adder #(.N(W)) u_addsub (
        .a    (a),
        .b    (is_sub ? ~b : b),
        .cin  (is_sub),
        .sum  (add_sum),
        .ovfl (add_ovfl)
    );

    logic [W-1:0]  padd_sum;
    logic [NL-1:0] lane_ovfl;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        sat_lane_adder #(.N(LANE_W)) u_lane (
            .a    (a[l*LANE_W +: LANE_W]),
            .b    (b[l*LANE_W +: LANE_W]),
            .cin  (1'b0),
            .sum  (padd_sum[l*LANE_W +: LANE_W]),
            .ovfl (lane_ovfl[l])
        );
    end

    logic [7:0] a_bytes [NB];
    logic [7:0] b_bytes [NB];

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign a_bytes[i] = a_q[i*8 +: 8];
        assign b_bytes[i] = b_q[i*8 +: 8];
    end

    logic [7:0]   a_byte;
    logic [7:0]   b_byte;
    logic [W-1:0] red_sum;

    assign a_byte  = a_bytes[cnt];
    assign b_byte  = b_bytes[cnt];
    assign red_sum = acc + {{(W-8){a_byte[7]}}, a_byte} + {{(W-8){b_byte[7]}}, b_byte};

    logic [W-1:0] one_res;
    logic         one_ovfl;
    logic         one_ill;

    always_comb begin
        one_res  = '0;
        one_ovfl = 1'b0;
        one_ill  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                one_res  = add_sum;
                one_ovfl = add_ovfl;
            end
            OP_PADD: begin
                one_res  = padd_sum;
                one_ovfl = |lane_ovfl;
            end
            OP_XOR:  one_res = a ^ b;
            OP_NAND: one_res = ~(a & b);
            OP_RED:  one_res = '0;
            default: one_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_RED) begin
                            state <= RED_ACC;
                            cnt   <= '0;
                            acc   <= '0;
                            a_q   <= a;
                            b_q   <= b;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= one_res;
                            ovfl      <= one_ovfl;
                            zero      <= (one_res == '0);
                            neg       <= one_res[W-1];
                            illegal   <= one_ill;
                        end
                    end
                end
                RED_ACC: begin
                    acc <= red_sum;
                    if (cnt == CW'(NB - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        result    <= red_sum;
                        ovfl      <= 1'b0;
                        zero      <= (red_sum == '0);
                        neg       <= red_sum[W-1];
                        illegal   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (W=16, LANE_W=4): directed cases from the
// block's behaviour plus randomized traffic against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         ovfl;
    logic         zero;
    logic         neg;
    logic         illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        ovfl;
        logic        ill;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t sb[$];

    alu_pipe #(.W(W), .LANE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi, output logic o);
        o = 1'b0;
        if (v > hi) begin o = 1'b1; return hi; end
        if (v < lo) begin o = 1'b1; return lo; end
        return v;
    endfunction

    // Reference: true signed arithmetic on integers, saturated to the range.
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int s;
        logic lo;
        logic [3:0] nx, ny;
        logic [7:0] bx, by;
        e = '0;
        case (o)
            3'd0: begin
                s = clamp(int'($signed(x)) + int'($signed(y)), -32768, 32767, lo);
                e.res = 16'(s); e.ovfl = lo;
            end
            3'd1: begin
                s = clamp(int'($signed(x)) - int'($signed(y)), -32768, 32767, lo);
                e.res = 16'(s); e.ovfl = lo;
            end
            3'd2: begin
                for (int l = 0; l < 4; l++) begin
                    nx = x[4*l +: 4];
                    ny = y[4*l +: 4];
                    s = clamp(int'($signed(nx)) + int'($signed(ny)), -8, 7, lo);
                    e.res[4*l +: 4] = 4'(s);
                    e.ovfl = e.ovfl | lo;
                end
            end
            3'd3: begin
                s = 0;
                for (int i = 0; i < 2; i++) begin
                    bx = x[8*i +: 8];
                    by = y[8*i +: 8];
                    s = s + int'($signed(bx)) + int'($signed(by));
                end
                e.res = 16'(s);
            end
            3'd4: e.res = x ^ y;
            3'd5: e.res = ~(x & y);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 16'h0);
        e.neg  = e.res[15];
        return e;
    endfunction

    function automatic logic [15:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Issue one op with out_ready=1 and check latency, result and flags.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] er, input logic eo,
                          input logic ei, input int elat);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o; a = x; b = y;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk({tag, "_busy_in_ready"}, in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, {ovfl, illegal, zero, neg}, {eo, ei, er == 16'h0, er[15]});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_output"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_out"}, {result, ovfl, illegal, zero, neg}, e);
        end
    endtask

    initial begin
        int acc_n, cyc;
        logic hold;
        logic [15:0] hold_res;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result", {result, ovfl, zero, neg, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Directed operations
        run_op("add_sat",  OP_ADD,  16'h7FFF, 16'h0001, 16'h7FFF, 1, 0, 1);
        run_op("sub_sat",  OP_SUB,  16'h8800, 16'h7700, 16'h8000, 1, 0, 1);
        run_op("sub_min",  OP_SUB,  16'h0000, 16'h8000, 16'h7FFF, 1, 0, 1);
        run_op("padd_a",   OP_PADD, 16'h8009, 16'h9009, 16'h8008, 1, 0, 1);
        run_op("padd_b",   OP_PADD, 16'h0FD8, 16'h0019, 16'h0FE8, 1, 0, 1);
        run_op("red_a",    OP_RED,  16'h0102, 16'h0304, 16'h000A, 0, 0, 3);
        run_op("red_b",    OP_RED,  16'h8080, 16'h8080, 16'hFE00, 0, 0, 3);
        run_op("xor",      OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 1);
        run_op("nand",     OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 1);

        // Back-pressure then same-cycle pop + accept
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = OP_ADD; a = 16'h1234; b = 16'h1111;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 16'h2345);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = OP_XOR; a = 16'h1234; b = 16'hFFFF;
        #1;
        chk("bp_pop_accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_xor_valid", out_valid, 1);
        chk("bp_xor_result", result, 16'hEDCB);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Reset in the middle of RED
        in_valid = 1'b1;
        op = OP_RED; a = 16'h0102; b = 16'h0304;
        @(negedge clk);
        in_valid = 1'b0;
        chk("red_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midred_rst_valid", out_valid, 0);
        chk("midred_rst_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midred_no_output", out_valid, 0);
        end
        run_op("add_after_rst", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 0, 0, 1);
        run_op("illegal6", 3'd6, 16'h1234, 16'h5678, 16'h0000, 0, 1, 1);
        run_op("illegal7", 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 1);

        // Randomized traffic against the scoreboard
        @(negedge clk);
        acc_n = 0;
        cyc = 0;
        hold = 1'b0;
        hold_res = '0;
        while (acc_n < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_result", result, hold_res);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            op = 3'($urandom_range(0, 7));
            a = rand_opnd();
            b = rand_opnd();
            #1;
            if (out_valid && out_ready) pop_check("rnd");
            hold = out_valid && !out_ready;
            hold_res = result;
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b));
                acc_n++;
            end
        end
        chk("rnd_accept_count", acc_n, 1000);

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            #1;
            if (out_valid) pop_check("drain");
            @(negedge clk);
            cyc++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("no_extra_output", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
